// File: rtl/dili_pkg.sv
// Shared constants and types for the Dilithium-field modular inverter.
package dili_pkg;

  localparam int unsigned Q           = 8380417;
  localparam int          DW          = 23;
  localparam int          RW          = 24;
  localparam int          E_W         = 23;
  localparam int          MUL_LAT_DEF = 4;

  // Fermat exponent Q-2; its MSB must be set for the left-to-right ladder.
  localparam logic [E_W-1:0] E = E_W'(Q - 2);

  typedef logic [DW-1:0] coef_t;

  typedef enum logic [2:0] {IDLE, SQR, MUL, WAIT, DONE} state_e;
  typedef enum logic       {OP_SQ, OP_ML}               op_e;

endpackage

// File: rtl/dili_mod_inv.sv
// Iterative a^(Q-2) mod Q using an external pipelined modular multiplier,
// left-to-right square-and-multiply with one multiplication in flight.
module dili_mod_inv
  import dili_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] a_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [DW-1:0] res_o,
  output logic          err_o,
  output logic          mul_vld_o,
  output logic [DW-1:0] mul_a_o,
  output logic [DW-1:0] mul_b_o,
  input  logic [RW-1:0] mul_res_i
);

  localparam int    CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int    IDX_W = $clog2(E_W);
  localparam coef_t Q_C   = coef_t'(Q);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  coef_t            acc_q, acc_d;
  coef_t            base_q, base_d;
  coef_t            res_q, res_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             mul_vld_q, mul_vld_d;
  coef_t            mul_a_q, mul_a_d;
  coef_t            mul_b_q, mul_b_d;

  // Reduced products are < Q < 2^DW, so the top result bit is always zero.
  coef_t mul_lo;
  logic  mul_res_unused;
  assign mul_lo         = mul_res_i[DW-1:0];
  assign mul_res_unused = mul_res_i[RW-1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    base_d  = base_q;
    res_d   = res_q;
    err_d   = err_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          res_d = '0;
          if (a_i == '0 || a_i >= Q_C) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            acc_d   = a_i;
            base_d  = a_i;
            idx_d   = IDX_W'(E_W - 2);
            state_d = SQR;
          end
        end
      end
      SQR: begin
        cnt_d   = CNT_W'(MUL_LAT - 1);
        op_d    = OP_SQ;
        state_d = WAIT;
      end
      MUL: begin
        cnt_d   = CNT_W'(MUL_LAT - 1);
        op_d    = OP_ML;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          acc_d = mul_lo;
          if (op_q == OP_SQ && E[idx_q]) begin
            state_d = MUL;
          end else if (idx_q == '0) begin
            res_d   = mul_lo;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    mul_vld_d = (state_d == SQR) || (state_d == MUL);
    mul_a_d   = mul_vld_d ? acc_d : '0;
    mul_b_d   = (state_d == SQR) ? acc_d : ((state_d == MUL) ? base_d : '0);
    ready_d   = (state_d == IDLE) || (state_d == DONE);
    done_d    = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_SQ;
      acc_q     <= '0;
      base_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      mul_vld_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      res_q     <= res_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      mul_vld_q <= mul_vld_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end

  assign ready_o   = ready_q;
  assign done_o    = done_q;
  assign res_o     = res_q;
  assign err_o     = err_q;
  assign mul_vld_o = mul_vld_q;
  assign mul_a_o   = mul_a_q;
  assign mul_b_o   = mul_b_q;

endmodule
